seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter COMMON_ANODE, default 1: 1 gives active-low an/seg; 0 gives active-high an/seg.
REQ-002 SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking; 0 disables it.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port tick, input, 1 bit: one-clk scan-enable pulse from the upstream clock divider.
REQ-006 SHALL have port load, input, 1 bit: request to convert and display bin.
REQ-007 SHALL have port bin, input, 14 bits: unsigned binary value, 0..16383.
REQ-008 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-009 SHALL have port done, output, 1 bit: one-clk pulse when new digits are committed.
REQ-010 SHALL have port overflow, output, 1 bit: the last committed value was >9999.
REQ-011 SHALL have port an, output, 4 bits: digit enables; an[0]=units … an[3]=thousands.
REQ-012 SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}.

Function
REQ-013 SHALL implement FSM states IDLE, CONV, COMMIT.
REQ-014 SHALL, in IDLE with load=1 at edge k: capture bin, clear the BCD shift register, enter CONV, and drive busy=1 from edge k.
REQ-015 SHALL, in CONV, perform one double-dabble step per clk (add 3 to each BCD nibble ≥5, then shift left by 1) for exactly 14 steps, on edges k+1..k+14.
REQ-016 SHALL, on edge k+15 (COMMIT), copy the BCD result into the display registers, pulse done=1 for one cycle, drive busy=0, and return to IDLE.
REQ-017 SHALL ignore load while busy=1, with no queuing.
REQ-018 SHALL, if the captured bin >9999, use the same latency, set overflow=1 at commit, and display "----" (segment g only, on all digits); otherwise clear overflow at commit.
REQ-019 SHALL update the display registers only in COMMIT, so the scan never shows partial results.
REQ-020 SHALL keep a 2-bit digit index that increments modulo 4 on each clk with tick=1 (3→0 wrap); tick has no effect otherwise.
REQ-021 SHALL register an/seg, updated one clk after the index changes, with exactly one digit enabled at any time.
REQ-022 SHALL, with BLANK_LZ=1, blank digit n (n=3..1) when it and all higher digits are 0; digit 0 is never blanked; overflow "----" is never blanked.
REQ-023 SHALL use active-high decode 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex), with a blank digit = 00 and dash = 40; when COMMON_ANODE=1, an and seg SHALL be inverted.
REQ-024 SHALL, when tick and a COMMIT fall in the same cycle, advance the scan and take the new digits for the next registered output.
REQ-025 SHALL treat undefined FSM encodings as IDLE.

Reset
REQ-026 SHALL apply reset=0 synchronously, with priority over load and tick.
REQ-027 SHALL, on reset, set state=IDLE, busy=0, done=0, overflow=0, digit index=0, and display registers=0 (shows "0" on units when BLANK_LZ=1).
REQ-028 SHALL, on reset, drive an and seg to all-off (4'b1111/7'b1111111 when COMMON_ANODE=1), then begin scanning from the first tick after reset release.
REQ-029 SHALL, on reset mid-conversion, abort without pulsing done and leave committed digits at 0.

Verification
REQ-030 SHALL cover: load, bin=1234 → busy high 15 cycles, done at edge k+15; over 4 ticks an/seg (active-low) show an=1110 seg=0011001 (4), 1101/0110000 (3), 1011/0100100 (2), 0111/1111001 (1).
REQ-031 SHALL cover: bin=7, BLANK_LZ=1 → units shows 1111000; digits 1..3 show seg=1111111; overflow=0.
REQ-032 SHALL cover: bin=10000 → overflow=1, all four digits seg=0111111 (dash), done after 15 cycles.
REQ-033 SHALL cover: load bin=42, then load bin=99 at k+5 → second load ignored, display shows 42, single done pulse.
REQ-034 SHALL cover: reset=0 at k+8 of a conversion of 9999 → no done, busy=0 next cycle, display "0", an/seg all-off until the first tick.
REQ-035 SHALL cover: 8 consecutive ticks with no load → index sequence 0,1,2,3,0,1,2,3, one-hot an throughout.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver with a serial double-dabble
// binary-to-BCD converter. A load captures a 14-bit value, converts it over
// 14 clocks and commits all four digits at once, so the scan never shows a
// half-converted number. Values above 9999 display "----".
module seg7_scan_driver #(
    parameter bit COMMON_ANODE = 1'b1,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    // Code 2'd3 is unused; the next-state default sends it through the IDLE path.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'b1111 : 4'b0000;
    localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'b1111111 : 7'b0000000;

    state_t          state, state_nxt;
    logic [3:0]      steps;      // double-dabble steps already taken
    logic [29:0]     dd;         // {thousands, hundreds, tens, units, binary}
    logic            big;        // captured value exceeds 9999
    logic [3:0][3:0] dig;        // committed digits, dig[0] = units
    logic [1:0]      idx;        // scan position
    logic            scan_on;    // set by the first tick after reset
    logic [6:0]      code;       // active-high segments for the current index
    logic [3:0]      onehot;

    // One double-dabble step: adjust each BCD nibble >= 5, then shift left.
    // The carry out of the thousands nibble is dropped; only values up to
    // 9999 are ever shown as digits.
    function automatic logic [29:0] dabble(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int n = 0; n < 4; n++) begin
            if (t[14 + 4*n +: 4] >= 4'd5)
                t[14 + 4*n +: 4] = t[14 + 4*n +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: 14 conversion steps, one commit cycle, then back to idle.
    always_comb begin
        state_nxt = state;
        case (state)
            CONV:    if (steps == 4'd13) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = load ? CONV : IDLE;
        endcase
    end

    // FSM outputs: busy from the load edge through the commit cycle.
    always_comb begin
        busy = (state == CONV) || (state == COMMIT);
    end

    // Converter datapath and committed display registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            steps    <= 4'd0;
            dd       <= 30'd0;
            big      <= 1'b0;
            dig      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                CONV: begin
                    dd    <= dabble(dd);
                    steps <= steps + 4'd1;
                end
                COMMIT: begin
                    dig      <= dd[29:14];
                    overflow <= big;
                    done     <= 1'b1;
                end
                default: begin
                    if (load) begin
                        dd    <= {16'd0, bin};
                        big   <= (bin > 14'd9999);
                        steps <= 4'd0;
                    end
                end
            endcase
        end
    end

    // Segment pattern for the digit at the current scan index, including
    // leading-zero blanking and the overflow dash.
    always_comb begin
        logic hz3, hz2, hz1, blank;
        hz3   = (dig[3] == 4'd0);
        hz2   = hz3 && (dig[2] == 4'd0);
        hz1   = hz2 && (dig[1] == 4'd0);
        blank = 1'b0;
        code  = 7'h00;
        if (BLANK_LZ) begin
            case (idx)
                2'd1:    blank = hz1;
                2'd2:    blank = hz2;
                2'd3:    blank = hz3;
                default: blank = 1'b0;
            endcase
        end
        if (overflow) begin
            code = 7'h40;
        end else if (!blank) begin
            case (dig[idx])
                4'd0:    code = 7'h3F;
                4'd1:    code = 7'h06;
                4'd2:    code = 7'h5B;
                4'd3:    code = 7'h4F;
                4'd4:    code = 7'h66;
                4'd5:    code = 7'h6D;
                4'd6:    code = 7'h7D;
                4'd7:    code = 7'h07;
                4'd8:    code = 7'h7F;
                4'd9:    code = 7'h6F;
                default: code = 7'h00;
            endcase
        end
        onehot = 4'b0001 << idx;
    end

    // Scan index and registered pin drive; pins stay dark until the first tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx     <= 2'd0;
            scan_on <= 1'b0;
            an      <= AN_OFF;
            seg     <= SEG_OFF;
        end else begin
            if (tick) begin
                idx     <= idx + 2'd1;
                scan_on <= 1'b1;
            end
            if (scan_on) begin
                an  <= COMMON_ANODE ? ~onehot : onehot;
                seg <= COMMON_ANODE ? ~code : code;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (common anode, leading-zero blanking).
// A transaction-level model (countdown latency, decimal arithmetic for the
// digits) predicts busy/done/overflow/an/seg after every clock.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset, tick, load;
    logic [13:0] bin;
    logic        busy, done, overflow;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_idx = 0, m_val = 0, m_pend = 0, m_left = 0;
    bit m_on = 0, m_ovf = 0, m_busy = 0;
    int n_done = 0, n_busy = 0;

    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int pow10 [4] = '{1, 10, 100, 1000};

    seg7_scan_driver #(.COMMON_ANODE(1'b1), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .bin(bin),
        .busy(busy), .done(done), .overflow(overflow), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_code(input int v, input bit ovf, input int i);
        if (ovf) return 7'h40;
        if (i > 0 && v < pow10[i]) return 7'h00;
        return tbl[(v / pow10[i]) % 10];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one clock of inputs, advance the model by one edge, compare.
    task automatic apply(input bit t, input bit l, input logic [13:0] b, input bit r);
        int p_idx, p_val;
        bit p_on, p_ovf, e_done;
        logic [3:0] ea;
        logic [6:0] es;
        tick = t; load = l; bin = b; reset = r;
        p_idx = m_idx; p_on = m_on; p_val = m_val; p_ovf = m_ovf;
        @(posedge clk); #1;
        e_done = 0;
        if (!r) begin
            m_idx = 0; m_on = 0; m_val = 0; m_ovf = 0; m_busy = 0; m_left = 0;
            p_on = 0;
        end else begin
            if (t) begin m_idx = (m_idx + 1) % 4; m_on = 1; end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_val = m_pend; m_ovf = (m_pend > 9999); e_done = 1;
                end
            end else if (l) begin
                m_busy = 1; m_left = 15; m_pend = int'(b);
            end
        end
        ea = p_on ? ~(4'b0001 << p_idx) : 4'b1111;
        es = p_on ? ~exp_code(p_val, p_ovf, p_idx) : 7'b1111111;
        if (done === 1'b1) n_done++;
        if (busy === 1'b1) n_busy++;
        chk("busy", busy, m_busy);
        chk("done", done, e_done);
        chk("overflow", overflow, m_ovf);
        chk("an", an, ea);
        chk("seg", seg, es);
    endtask

    task automatic conv(input int v, input bit t);
        apply(t, 1, v[13:0], 1);
        repeat (15) apply(t, 0, 14'd0, 1);
    endtask

    initial begin
        tick = 0; load = 0; bin = 0; reset = 0;
        // reset, with tick asserted to show reset wins
        apply(0, 0, 14'd0, 0);
        apply(1, 1, 14'd55, 0);
        repeat (3) apply(0, 0, 14'd0, 1);           // dark until the first tick
        repeat (8) apply(1, 0, 14'd0, 1);           // free scan, shows "0" on units
        apply(0, 0, 14'd0, 1);

        // 1234: 15 busy cycles, single done at k+15, then scan all digits
        n_done = 0; n_busy = 0;
        conv(1234, 0);
        chk("done_cnt_1234", n_done, 1);
        chk("busy_cycles_1234", n_busy, 15);
        repeat (6) apply(1, 0, 14'd0, 1);
        apply(0, 0, 14'd0, 1);

        // 7 with leading-zero blanking
        conv(7, 0);
        repeat (5) apply(1, 0, 14'd0, 1);
        chk("ovf_7", overflow, 1'b0);

        // 10000 overflows: dashes on every digit, same latency
        n_done = 0;
        conv(10000, 0);
        chk("done_cnt_10000", n_done, 1);
        repeat (5) apply(1, 0, 14'd0, 1);
        chk("seg_dash", seg, 7'b0111111);

        // 42, then 99 at k+5 is ignored
        n_done = 0;
        apply(0, 1, 14'd42, 1);
        repeat (4) apply(0, 0, 14'd0, 1);
        apply(0, 1, 14'd99, 1);
        repeat (12) apply(0, 0, 14'd0, 1);
        chk("done_cnt_42", n_done, 1);
        repeat (5) apply(1, 0, 14'd0, 1);

        // tick every cycle, so one lands on the commit edge
        conv(3056, 1);
        repeat (5) apply(1, 0, 14'd0, 1);

        // reset at k+8 of 9999: abort, no done, dark until tick, then "0"
        n_done = 0;
        apply(0, 1, 14'd9999, 1);
        repeat (7) apply(0, 0, 14'd0, 1);
        apply(0, 0, 14'd0, 0);
        repeat (20) apply(0, 0, 14'd0, 1);
        chk("done_cnt_abort", n_done, 0);
        repeat (6) apply(1, 0, 14'd0, 1);

        // randomized loads and ticks
        for (int i = 0; i < 30; i++) begin
            int v;
            v = ($urandom % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 999));
            apply($urandom % 2, 1, v[13:0], 1);
            repeat (16 + $urandom % 4)
                apply($urandom % 2, ($urandom % 4) == 0, 14'($urandom % 16384), 1);
            repeat (5) apply(1, 0, 14'd0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
